speck_iter_engine: RTL

- Parametrised iterative SPECK block cipher engine; one round per clock; encrypt and decrypt modes.
- Expands the master key into an internal round-key buffer, then runs the round datapath over that buffer.
- Can reuse a previously expanded key to skip expansion.
- Top-level crypto controllers instantiate it in place of hand-sequenced round/key-schedule pairs.

---
 rtl/speck_iter_engine.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/speck_iter_engine.sv
// Iterative SPECK engine: expands the master key into a round-key buffer, then
// runs one encrypt or decrypt round per clock over that buffer.
module speck_iter_engine #(
    parameter int unsigned WORD      = 64,
    parameter int unsigned KEY_WORDS = 2,
    parameter int unsigned ROUNDS    = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        decrypt,
    input  logic                        reuse_key,
    input  logic [KEY_WORDS*WORD-1:0]   key,
    input  logic [2*WORD-1:0]           block_in,
    output logic                        ready,
    output logic                        busy,
    output logic                        done,
    output logic [2*WORD-1:0]           block_out,
    output logic                        key_cached
);

    localparam int unsigned ALPHA = (WORD == 16) ? 7 : 8;
    localparam int unsigned BETA  = (WORD == 16) ? 2 : 3;
    localparam int unsigned CW    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int unsigned KW    = KEY_WORDS * WORD;
    localparam int unsigned LW    = (KEY_WORDS - 1) * WORD;
    localparam int unsigned BW    = 2 * WORD;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_CRYPT  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    function automatic logic [WORD-1:0] ror(input logic [WORD-1:0] v, input int unsigned n);
        return (v >> n) | (v << (WORD - n));
    endfunction

    function automatic logic [WORD-1:0] rol(input logic [WORD-1:0] v, input int unsigned n);
        return (v << n) | (v >> (WORD - n));
    endfunction

    state_t              state_q, state_d;
    logic                ready_d, busy_d, done_d;
    logic [CW-1:0]       ctr_q;
    logic                mode_q;
    logic [WORD-1:0]     x_q, y_q, k_q;
    logic [LW-1:0]       l_q;
    logic [WORD-1:0]     rk [ROUNDS];

    logic                accept, cache_hit, exp_last, crypt_last;
    logic [CW-1:0]       ctr_inc, ctr_dec, crypt_init_idle, crypt_init_exp;
    logic [WORD-1:0]     ks_l, ks_k, rk_cur;
    logic [LW-1:0]       l_shift;
    logic [WORD-1:0]     enc_x, enc_y, dec_x, dec_y, rnd_x, rnd_y;

    assign accept          = (state_q == S_IDLE) && start;
    assign cache_hit       = reuse_key && key_cached;
    assign ctr_inc         = ctr_q + CW'(1);
    assign ctr_dec         = ctr_q - CW'(1);
    assign exp_last        = (ctr_q == CW'(ROUNDS - 2));
    assign crypt_last      = mode_q ? (ctr_q == '0) : (ctr_q == CW'(ROUNDS - 1));
    assign crypt_init_idle = decrypt ? CW'(ROUNDS - 1) : '0;
    assign crypt_init_exp  = mode_q  ? CW'(ROUNDS - 1) : '0;

    // Key-schedule step: i is the current counter value.
    assign ks_l = (k_q + ror(l_q[WORD-1:0], ALPHA)) ^ WORD'(ctr_q);
    assign ks_k = rol(k_q, BETA) ^ ks_l;

    generate
        if (KEY_WORDS == 2) begin : g_l_single
            assign l_shift = ks_l;
        end else begin : g_l_multi
            assign l_shift = {ks_l, l_q[LW-1:WORD]};
        end
    endgenerate

    // Round datapath, both directions.
    assign rk_cur = rk[ctr_q];
    assign enc_x  = (ror(x_q, ALPHA) + y_q) ^ rk_cur;
    assign enc_y  = rol(y_q, BETA) ^ enc_x;
    assign dec_y  = ror(x_q ^ y_q, BETA);
    assign dec_x  = rol((x_q ^ rk_cur) - dec_y, ALPHA);
    assign rnd_x  = mode_q ? dec_x : enc_x;
    assign rnd_y  = mode_q ? dec_y : enc_y;

    // State register with registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            ready   <= ready_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = cache_hit ? S_CRYPT : S_EXPAND;
            S_EXPAND: if (exp_last) state_d = S_CRYPT;
            S_CRYPT:  if (crypt_last) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Flags are computed from the next state so they line up with it.
    always_comb begin
        ready_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_d)
            S_IDLE:   ready_d = 1'b1;
            S_EXPAND: busy_d  = 1'b1;
            S_CRYPT:  busy_d  = 1'b1;
            S_DONE:   done_d  = 1'b1;
            default:  ready_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_q      <= '0;
            mode_q     <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            k_q        <= '0;
            l_q        <= '0;
            block_out  <= '0;
            key_cached <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q <= decrypt;
                        x_q    <= block_in[BW-1:WORD];
                        y_q    <= block_in[WORD-1:0];
                        if (cache_hit) begin
                            ctr_q <= crypt_init_idle;
                        end else begin
                            k_q        <= key[WORD-1:0];
                            l_q        <= key[KW-1:WORD];
                            key_cached <= 1'b0;
                            ctr_q      <= '0;
                        end
                    end
                end
                S_EXPAND: begin
                    k_q <= ks_k;
                    l_q <= l_shift;
                    if (exp_last) begin
                        key_cached <= 1'b1;
                        ctr_q      <= crypt_init_exp;
                    end else begin
                        ctr_q <= ctr_inc;
                    end
                end
                S_CRYPT: begin
                    x_q <= rnd_x;
                    y_q <= rnd_y;
                    if (crypt_last) begin
                        block_out <= {rnd_x, rnd_y};
                    end else begin
                        ctr_q <= mode_q ? ctr_dec : ctr_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Round-key buffer; contents are meaningless until key_cached is set.
    always_ff @(posedge clk) begin
        if (accept && !cache_hit) begin
            rk[0] <= key[WORD-1:0];
        end else if (state_q == S_EXPAND) begin
            rk[ctr_inc] <= ks_k;
        end
    end

endmodule
